// File: rtl/wb_obi_pkg.sv
// Shared types and constants for the Wishbone-to-OBI responder bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_obi_pkg;

  // Raw state encodings, kept as plain constants for legacy users of the codes.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RESP  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    RESP  = ST_RESP,
    ACK   = ST_ACK,
    DRAIN = ST_DRAIN
  } state_e;

  // Read data returned alongside a WB error when the OBI side does not answer.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/wb_obi_timeout.sv
// Watchdog counter: cleared while idle, counts while enabled, flags the last allowed cycle.
// Latency: expired is combinational from the counter register (valid in the cycle it applies to).
// Backpressure: none; the owner decides what an expiry means.
module wb_obi_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    // Timeout disabled: no counter at all.
    logic unused_inputs;
    assign unused_inputs = clk_i ^ rst_ni ^ clr ^ en;
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles, saturating so a late grant cannot wrap the budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (en && (cnt_q != TOP)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    // Once the budget is used up it stays used up, so a grant that just beat the
    // deadline leaves no further slack for the response wait.
    assign expired = en && (cnt_q >= LAST);
  end

endmodule

// File: rtl/wb_obi_bridge.sv
// Wishbone-classic responder issuing one OBI initiator transfer per WB cycle, with watchdog.
// Latency: ack 3 cycles after stb at best; +1 per gnt or rvalid wait cycle; error after TIMEOUT_CYCLES.
// Backpressure: WB stalls (no ack) until the OBI side grants and responds; one transfer outstanding.
module wb_obi_bridge
  import wb_obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_wdata_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_rdata_o,
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [31:0]           obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i
);

  state_e      state_q, state_d;
  logic        abort_q, abort_d;
  logic        obi_req_d;
  logic        ack_d, err_d;
  logic [31:0] rdata_d;
  logic        latch_req;
  logic        tmo_fire;
  logic        abort_now;
  logic        tmo_clr, tmo_en, tmo_expired;

  // A master that has dropped cyc this cycle counts as aborted even before the flag lands.
  assign abort_now = abort_q | ~wb_cyc_i;
  assign tmo_clr   = (state_q == IDLE);
  assign tmo_en    = (state_q == REQ) || (state_q == RESP);

  wb_obi_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  // Next-state and response decode for the single-outstanding transfer FSM.
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    obi_req_d = obi_req_o;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = wb_rdata_o;
    latch_req = 1'b0;
    tmo_fire  = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          latch_req = 1'b1;
          obi_req_d = 1'b1;
          state_d   = REQ;
        end
      end

      REQ: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        // A grant on the expiry edge still wins.
        if (obi_gnt_i) begin
          obi_req_d = 1'b0;
          state_d   = RESP;
        end else if (tmo_expired) begin
          // Request stays up: the OBI transfer must still be granted and drained.
          tmo_fire = 1'b1;
          state_d  = DRAIN;
        end
      end

      RESP: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (obi_rvalid_i) begin
          // Loaded for writes too; the master ignores it then.
          rdata_d = obi_rdata_i;
          if (abort_now) begin
            state_d = IDLE;
          end else begin
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else if (tmo_expired) begin
          tmo_fire = 1'b1;
          state_d  = DRAIN;
        end
      end

      ACK: begin
        // The master drops stb on seeing ack, so nothing is sampled here.
        state_d = IDLE;
      end

      DRAIN: begin
        // Finish the orphaned OBI transfer silently; obi_req_o tells which phase is left.
        if (obi_req_o) begin
          if (obi_gnt_i) obi_req_d = 1'b0;
        end else if (obi_rvalid_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        obi_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // An aborted master gets no error, only the silent drain.
    if (tmo_fire && !abort_now) begin
      err_d   = 1'b1;
      rdata_d = ERR_RDATA;
    end
  end

  // FSM state, abort flag and WB response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      abort_q    <= 1'b0;
      obi_req_o  <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_rdata_o <= '0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      obi_req_o  <= obi_req_d;
      wb_ack_o   <= ack_d;
      wb_err_o   <= err_d;
      wb_rdata_o <= rdata_d;
    end
  end

  // OBI request fields only change when a new WB request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obi_addr_o  <= '0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_wdata_o <= '0;
    end else if (latch_req) begin
      obi_addr_o  <= wb_addr_i;
      obi_we_o    <= wb_we_i;
      obi_be_o    <= wb_sel_i;
      obi_wdata_o <= wb_wdata_i;
    end
  end

endmodule
